alu_seq: RTL
============

# alu_seq

Parametrised successor to the single-cycle datapath ALU: a registered, handshaked execute unit for the MIPS core. It keeps the existing 4-bit operation encoding and adds iterative unsigned multiply and divide with a HI/LO result pair. Single-cycle operations complete in one clock. Multiply and divide occupy the unit for WIDTH iterations. It sits in the EX stage, and the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width; derived, not overridden.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: issue request; accepted only when `busy`=0.
- `a`, input, WIDTH: source 1; sampled on accept.
- `b`, input, WIDTH: source 2; sampled on accept.
- `alu_control`, input, 4: operation select; sampled on accept.
- `busy`, output, 1: high while an iterative operation is in progress.
- `done`, output, 1: one-cycle pulse; `result`/`hi`/flags valid in that cycle and held until the next `done`.
- `result`, output, WIDTH: primary result (LO for multiply/divide).
- `hi`, output, WIDTH: upper product or remainder; 0 for single-cycle operations.
- `zero`, output, 1: `result` == 0; registered together with `result`.
- `div_by_zero`, output, 1: set with `done` for divide when `b`=0; cleared on the next `done`.

## Operation
- Encoding (unchanged codes):
  - 0000: AND
  - 0001: OR
  - 0010: ADD (modulo 2^WIDTH)
  - 0110: SUB (modulo 2^WIDTH)
  - 0111: unsigned MIN, i.e. (a>b)?b:a
  - 1100: XNOR
  - 0011: pass a (JR)
- New codes:
  - 1000: MULTU, giving {hi,result} = a*b as a 2·WIDTH-bit unsigned product.
  - 1001: DIVU, giving result = a/b and hi = a%b.
- Any other code: result=0, hi=0, zero=1. No latch and no hold of the old value.
- States: IDLE, RUN.
  - IDLE + start + single-cycle op: register outputs and pulse `done` next cycle; stay in IDLE.
  - IDLE + start + MULTU/DIVU: load operands, clear accumulator, counter=WIDTH, go to RUN; `busy`=1 from the next cycle.
  - RUN: one iteration per cycle, decrementing the counter.
    - MULTU uses shift-add.
    - DIVU uses restoring division.
  - RUN with counter reaching 0: write hi/result, pulse `done`, drop `busy`, return to IDLE.
- `start` while `busy`=1 is ignored. No queueing.
- `start` in the `done` cycle of an iterative op is accepted, because the state is already IDLE.
- Divide by zero runs the full WIDTH iterations. Result is all-ones, hi = a, `div_by_zero`=1.
- Operands are captured at accept. Changes on `a`/`b`/`alu_control` during RUN have no effect.

## Timing
- Reset, at any time including mid-RUN: next state IDLE, busy=0, done=0, result=0, hi=0, zero=1, div_by_zero=0. Any in-flight operation is discarded with no `done`.
- Single-cycle op accepted at edge N: `done` and result visible after edge N+1 (latency 1).
- MULTU/DIVU accepted at edge N:
  - `busy`=1 after edges N+1 … N+WIDTH.
  - `done`=1 and `busy`=0 after edge N+WIDTH+1 (latency WIDTH+1, i.e. 33 cycles for WIDTH=32).
- Back-to-back single-cycle issues give one result per cycle. `done` stays high on consecutive cycles.
- `zero` reflects only `result`, never `hi`.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MIN, ALU_XNOR, ALU_JR, ALU_MULTU, ALU_DIVU.
  - state enum {IDLE, RUN}.
  - These are shared with the decoder/control unit.
- Sub-module `alu_iter`: the WIDTH-parametrised shift-add/restoring datapath. It has `clk`/`reset`, load/step/mode inputs, and {hi,lo} outputs.
- Top `alu_seq` owns the FSM, counter, single-cycle combinational ops and the output registers.

## Test plan
- Reset mid-MULTU: issue MULTU, assert `reset` at cycle 10 → busy=0, result=0, hi=0, zero=1, and no `done` ever appears.
- Single-cycle sweep, WIDTH=32, a=0xF0F0_0005, b=0x0000_0007:
  - AND: 0x5
  - OR: 0xF0F0_0007
  - ADD: 0xF0F0_000C
  - SUB: 0xF0EF_FFFE
  - MIN: 0x7
  - XNOR: 0x0F0F_FFFD
  - JR: 0xF0F0_0005
  - Each has `done` exactly one cycle after `start`.
- MULTU a=b=0xFFFF_FFFF → hi=0xFFFF_FFFE, result=0x0000_0001, done at start+33, busy high for exactly 32 cycles.
- DIVU a=100, b=7 → result=14, hi=2, div_by_zero=0. Then a=0x1234, b=0 → result=0xFFFF_FFFF, hi=0x1234, div_by_zero=1.
- Issue SUB a=b=5 while busy → ignored. Re-issue in the `done` cycle → accepted; next cycle result=0, zero=1.
- Undefined code 1111 → result=0, hi=0, zero=1; repeat with WIDTH=8 for MULTU 0xFF*0xFF → hi=0xFE, result=0x01 at start+9.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encoding and shared types for the EX-stage execute unit and the
// decoder/control unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_JR    = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_MIN   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_XNOR  = 4'b1100;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic {
        ITER_MUL,
        ITER_DIV
    } iter_mode_t;

endpackage

// File: rtl/alu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider. hi/lo present
// the {acc, lo} pair as it will be after the current step.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  iter_mode_t       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        hi      = acc_q;
        lo      = lo_q;
        sum     = '0;
        shifted = '0;
        ge      = 1'b0;
        if (mode == ITER_MUL) begin
            sum = {1'b0, acc_q} + {1'b0, opnd_q & {WIDTH{lo_q[0]}}};
            hi  = sum[WIDTH:1];
            lo  = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            // Remainder < divisor, so the difference always fits in WIDTH bits.
            shifted = {acc_q, lo_q[WIDTH-1]};
            ge      = (shifted >= {1'b0, opnd_q});
            hi      = ge ? (shifted[WIDTH-1:0] - opnd_q) : shifted[WIDTH-1:0];
            lo      = {lo_q[WIDTH-2:0], ge};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= '0;
            lo_q   <= a;
            opnd_q <= b;
        end else if (step) begin
            acc_q <= hi;
            lo_q  <= lo;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked EX-stage ALU: single-cycle ops complete in one clock,
// MULTU/DIVU run WIDTH iterations in alu_iter while busy stalls the pipeline.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero
);

    state_t           state;
    iter_mode_t       mode_q;
    logic [CNT_W-1:0] count;
    logic             dbz_pend;
    logic             accept;
    logic             is_iter;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign accept  = start && (state == IDLE);
    assign is_iter = (alu_control == ALU_MULTU) || (alu_control == ALU_DIVU);
    assign busy    = (state == RUN);

    always_comb begin
        sc_result = '0;
        case (alu_control)
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_ADD:  sc_result = a + b;
            ALU_SUB:  sc_result = a - b;
            ALU_MIN:  sc_result = (a > b) ? b : a;
            ALU_XNOR: sc_result = ~(a ^ b);
            ALU_JR:   sc_result = a;
            default:  sc_result = '0;
        endcase
    end

    alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk  (clk),
        .reset(reset),
        .load (accept && is_iter),
        .step (state == RUN),
        .mode (mode_q),
        .a    (a),
        .b    (b),
        .hi   (iter_hi),
        .lo   (iter_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= ITER_MUL;
            count       <= '0;
            dbz_pend    <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state    <= RUN;
                            count    <= CNT_W'(WIDTH);
                            mode_q   <= (alu_control == ALU_DIVU) ? ITER_DIV : ITER_MUL;
                            dbz_pend <= (alu_control == ALU_DIVU) && (b == '0);
                        end else begin
                            done        <= 1'b1;
                            result      <= sc_result;
                            hi          <= '0;
                            zero        <= (sc_result == '0);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    // The final step's outcome is written straight to the outputs.
                    if (count == CNT_W'(1)) begin
                        state       <= IDLE;
                        done        <= 1'b1;
                        result      <= iter_lo;
                        hi          <= iter_hi;
                        zero        <= (iter_lo == '0);
                        div_by_zero <= dbz_pend;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
